// File: rtl/password_pkg.sv
// password_pkg -- shared types and constants for the password setter.
//   state_e          : FSM state encoding; each value equals its status code
//   STATUS_*         : status word values driven to the display block
//   NUM_DIGITS       : digits in one code entry
//   DEFAULT_CODE_INIT: code loaded at reset (first digit in [15:12])
//   state_to_status  : maps an FSM state onto the 4-bit status word
// Optional feature macro used by the design: PASSWORD_CONFIRM_EN.
package password_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTER    = 3'd1,
    S_CONFIRM  = 3'd2,
    S_SAVED    = 3'd3,
    S_MISMATCH = 3'd4,
    S_TIMEOUT  = 3'd5
  } state_e;

  localparam logic [3:0] STATUS_IDLE     = 4'd0;
  localparam logic [3:0] STATUS_ENTER    = 4'd1;
  localparam logic [3:0] STATUS_CONFIRM  = 4'd2;
  localparam logic [3:0] STATUS_SAVED    = 4'd3;
  localparam logic [3:0] STATUS_MISMATCH = 4'd4;
  localparam logic [3:0] STATUS_TIMEOUT  = 4'd5;

  localparam int NUM_DIGITS = 4;

  localparam logic [15:0] DEFAULT_CODE_INIT = 16'h1234;

  function automatic logic [3:0] state_to_status(input state_e s);
    logic [3:0] st;
    case (s)
      S_ENTER:    st = STATUS_ENTER;
      S_CONFIRM:  st = STATUS_CONFIRM;
      S_SAVED:    st = STATUS_SAVED;
      S_MISMATCH: st = STATUS_MISMATCH;
      S_TIMEOUT:  st = STATUS_TIMEOUT;
      default:    st = STATUS_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/key_encoder.sv
// key_encoder -- turns the 10-bit one-shot key bank into a BCD digit.
//   key_i   [9:0] : one-shot key pulses, bit n is digit n
//   valid_o       : high only when exactly one key bit is set
//   digit_o [3:0] : index of the set bit (meaningful only when valid_o)
module key_encoder (
  input  logic [9:0] key_i,
  output logic       valid_o,
  output logic [3:0] digit_o
);

  // OR-ing the indices of all set bits is only correct for a single set
  // bit, which is exactly the case where valid_o qualifies the digit.
  always_comb begin
    valid_o = $onehot(key_i);
    digit_o = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_i[i]) digit_o = digit_o | 4'(i);
    end
  end

endmodule

// File: rtl/password_setter.sv
// password_setter -- captures a new 4-digit code from one-shot key pulses,
// optionally requires a matching second entry, and commits it to `code`.
//   clk            : 1 kHz divided clock
//   rst            : synchronous active-high reset
//   prog_start     : pulse that starts / restarts programming
//   key_pulse [9:0]: one-shot key pulses, bit n is digit n
//   code     [15:0]: committed password, four BCD nibbles
//   code_valid     : one-cycle pulse when `code` is written
//   status    [3:0]: 0 IDLE,1 ENTER,2 CONFIRM,3 SAVED,4 MISMATCH,5 TIMEOUT
//   digit_cnt [2:0]: digits captured in the current pass
//   busy           : high in ENTER or CONFIRM
// Macro PASSWORD_CONFIRM_EN: when defined, a second matching entry is
// required before committing; otherwise the 4th digit commits directly.
module password_setter
  import password_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE   = DEFAULT_CODE_INIT,
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter int          HOLD_CYCLES    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_start,
  input  logic [9:0]  key_pulse,
  output logic [15:0] code,
  output logic        code_valid,
  output logic [3:0]  status,
  output logic [2:0]  digit_cnt,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
  localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic       key_valid;
  logic [3:0] key_digit;

  key_encoder u_key_encoder (
    .key_i   (key_pulse),
    .valid_o (key_valid),
    .digit_o (key_digit)
  );

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  // First three digits of the pass in progress; the 4th digit is joined
  // combinationally so a complete code is available on the 4th key edge.
  logic [11:0]   part_q, part_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   code_q, code_d;
  logic          code_valid_q, code_valid_d;
  logic [15:0]   full_code;
`ifdef PASSWORD_CONFIRM_EN
  logic [15:0]   first_q, first_d;   // completed first entry awaiting confirmation
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    part_d       = part_q;
    timer_d      = timer_q;
    hold_d       = hold_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
`ifdef PASSWORD_CONFIRM_EN
    first_d      = first_q;
`endif
    full_code    = {part_q, key_digit};

    // prog_start outranks everything, including a key in the same cycle.
    if (prog_start) begin
      state_d = S_ENTER;
      cnt_d   = '0;
      part_d  = '0;
      timer_d = '0;
      hold_d  = '0;
`ifdef PASSWORD_CONFIRM_EN
      first_d = '0;
`endif
    end else begin
      case (state_q)
        S_ENTER, S_CONFIRM: begin
          if (key_valid) begin
            timer_d = '0;
            if (cnt_q == LAST_DIGIT) begin
              part_d = '0;
              cnt_d  = 3'(NUM_DIGITS);
              hold_d = '0;
`ifdef PASSWORD_CONFIRM_EN
              if (state_q == S_ENTER) begin
                first_d = full_code;
                cnt_d   = '0;
                state_d = S_CONFIRM;
              end else if (full_code == first_q) begin
                code_d       = full_code;
                code_valid_d = 1'b1;
                first_d      = '0;
                state_d      = S_SAVED;
              end else begin
                first_d = '0;
                state_d = S_MISMATCH;
              end
`else
              code_d       = full_code;
              code_valid_d = 1'b1;
              state_d      = S_SAVED;
`endif
            end else begin
              part_d = {part_q[7:0], key_digit};
              cnt_d  = cnt_q + 3'd1;
            end
          end else if (timer_q == TIMER_LAST) begin
            // This edge makes the timer read TIMEOUT_CYCLES.
            timer_d = TIMER_MAX;
            state_d = S_TIMEOUT;
            part_d  = '0;
            cnt_d   = '0;
            hold_d  = '0;
`ifdef PASSWORD_CONFIRM_EN
            first_d = '0;
`endif
          end else if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_SAVED, S_MISMATCH, S_TIMEOUT: begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_IDLE;
            hold_d  = '0;
            cnt_d   = '0;
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      part_q       <= '0;
      timer_q      <= '0;
      hold_q       <= '0;
      code_q       <= DEFAULT_CODE;
      code_valid_q <= 1'b0;
`ifdef PASSWORD_CONFIRM_EN
      first_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      part_q       <= part_d;
      timer_q      <= timer_d;
      hold_q       <= hold_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
`ifdef PASSWORD_CONFIRM_EN
      first_q      <= first_d;
`endif
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign digit_cnt  = cnt_q;
  assign status     = state_to_status(state_q);
  assign busy       = (state_q == S_ENTER) || (state_q == S_CONFIRM);

endmodule

// File: tb/tb_password_setter.sv
module tb_password_setter;

  localparam int T = 5000;
  localparam int H = 1000;

  logic        clk;
  logic        rst;
  logic        prog_start;
  logic [9:0]  key_pulse;
  logic [15:0] code;
  logic        code_valid;
  logic [3:0]  status;
  logic [2:0]  digit_cnt;
  logic        busy;

  password_setter #(
    .DEFAULT_CODE   (16'h1234),
    .TIMEOUT_CYCLES (T),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_start (prog_start),
    .key_pulse  (key_pulse),
    .code       (code),
    .code_valid (code_valid),
    .status     (status),
    .digit_cnt  (digit_cnt),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        r;
    logic        p;
    logic [9:0]  keys;
    int          reps;
    logic [3:0]  st;
    logic [2:0]  cnt;
    logic        cc;     // compare digit_cnt on this vector
    logic [15:0] cd;
    logic        cv;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  int total  = 0;
  int passed = 0;
  int cv_seen = 0;

  always @(negedge clk) if (code_valid === 1'b1) cv_seen++;

  function automatic logic [9:0] kd(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic add(input string nm, input logic r, input logic p, input logic [9:0] k,
                     input int reps, input int st, input int cnt, input logic cc,
                     input logic [15:0] cd, input logic cv);
    vec_t v;
    v.name = nm; v.r = r; v.p = p; v.keys = k; v.reps = reps;
    v.st = 4'(st); v.cnt = 3'(cnt); v.cc = cc; v.cd = cd; v.cv = cv;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      rst        = tbl[i].r;
      prog_start = tbl[i].p;
      key_pulse  = tbl[i].keys;
      sb.push_back(tbl[i]);
      for (int n = 0; n < tbl[i].reps; n++) tick();
      rst = 1'b0; prog_start = 1'b0; key_pulse = '0;
      e = sb.pop_front();
      chk({e.name, ".status"}, 32'(status), 32'(e.st));
      chk({e.name, ".busy"}, 32'(busy), 32'((e.st == 4'd1) || (e.st == 4'd2)));
      chk({e.name, ".code"}, 32'(code), 32'(e.cd));
      chk({e.name, ".code_valid"}, 32'(code_valid), 32'(e.cv));
      if (e.cc) chk({e.name, ".digit_cnt"}, 32'(digit_cnt), 32'(e.cnt));
      $display("vec %-14s st=%0d cnt=%0d code=%h cv=%0b", e.name, status, digit_cnt, code, code_valid);
    end
    tbl.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int cv_base;

  initial begin
    rst = 1'b1; prog_start = 1'b0; key_pulse = '0;
    tick(); tick();

    // Scenario 1: program 5092 and watch the hold period expire.
    cv_base = cv_seen;
    add("s1_rst", 1, 0, 0, 2, 0, 0, 1, 16'h1234, 0);
    add("s1_prog", 0, 1, 0, 1, 1, 0, 1, 16'h1234, 0);
    add("s1_k5", 0, 0, kd(5), 1, 1, 1, 1, 16'h1234, 0);
    add("s1_k0", 0, 0, kd(0), 1, 1, 2, 1, 16'h1234, 0);
    add("s1_k9", 0, 0, kd(9), 1, 1, 3, 1, 16'h1234, 0);
`ifdef PASSWORD_CONFIRM_EN
    add("s1_k2", 0, 0, kd(2), 1, 2, 0, 1, 16'h1234, 0);
    add("s1_c5", 0, 0, kd(5), 1, 2, 1, 1, 16'h1234, 0);
    add("s1_c0", 0, 0, kd(0), 1, 2, 2, 1, 16'h1234, 0);
    add("s1_c9", 0, 0, kd(9), 1, 2, 3, 1, 16'h1234, 0);
    add("s1_c2", 0, 0, kd(2), 1, 3, 0, 0, 16'h5092, 1);
`else
    add("s1_k2", 0, 0, kd(2), 1, 3, 0, 0, 16'h5092, 1);
`endif
    run_table();
    // Hand-written: result state lasts H cycles, IDLE on the following edge.
    for (int n = 0; n < H - 1; n++) tick();
    chk("s1_hold_last.status", 32'(status), 32'd3);
    tick();
    chk("s1_hold_done.status", 32'(status), 32'd0);
    chk("s1_hold_done.busy", 32'(busy), 32'd0);
    chk("s1_hold_done.code", 32'(code), 32'h5092);
    chk("s1_cv_pulses", 32'(cv_seen - cv_base), 32'd1);
    $display("seq s1_hold status=%0d code=%h pulses=%0d", status, code, cv_seen - cv_base);

    // Scenario 2: mismatched confirmation (or direct commit without confirm).
    add("s2_rst", 1, 0, 0, 1, 0, 0, 1, 16'h1234, 0);
    add("s2_prog", 0, 1, 0, 1, 1, 0, 1, 16'h1234, 0);
    add("s2_k1", 0, 0, kd(1), 1, 1, 1, 1, 16'h1234, 0);
    add("s2_k2", 0, 0, kd(2), 1, 1, 2, 1, 16'h1234, 0);
    add("s2_k3", 0, 0, kd(3), 1, 1, 3, 1, 16'h1234, 0);
`ifdef PASSWORD_CONFIRM_EN
    add("s2_k4", 0, 0, kd(4), 1, 2, 0, 1, 16'h1234, 0);
    add("s2_c1", 0, 0, kd(1), 1, 2, 1, 1, 16'h1234, 0);
    add("s2_c2", 0, 0, kd(2), 1, 2, 2, 1, 16'h1234, 0);
    add("s2_c3", 0, 0, kd(3), 1, 2, 3, 1, 16'h1234, 0);
    add("s2_c5", 0, 0, kd(5), 1, 4, 0, 0, 16'h1234, 0);
`else
    add("s2_k4", 0, 0, kd(4), 1, 3, 0, 0, 16'h1234, 1);
`endif
    // Scenario 3: multi-bit key ignored, timeout counted from the last valid key.
    add("s3_rst", 1, 0, 0, 1, 0, 0, 1, 16'h1234, 0);
    add("s3_prog", 0, 1, 0, 1, 1, 0, 1, 16'h1234, 0);
    add("s3_k3", 0, 0, kd(3), 1, 1, 1, 1, 16'h1234, 0);
    add("s3_multi", 0, 0, 10'b0000000011, 1, 1, 1, 1, 16'h1234, 0);
    add("s3_wait", 0, 0, 0, T - 2, 1, 1, 1, 16'h1234, 0);
    add("s3_timeout", 0, 0, 0, 1, 5, 0, 0, 16'h1234, 0);
    add("s3_restart", 0, 1, 0, 1, 1, 0, 1, 16'h1234, 0);
    // Scenario 4: prog_start beats a simultaneous key 7.
    add("s4_rst", 1, 0, 0, 1, 0, 0, 1, 16'h1234, 0);
    add("s4_prog", 0, 1, 0, 1, 1, 0, 1, 16'h1234, 0);
    add("s4_k1", 0, 0, kd(1), 1, 1, 1, 1, 16'h1234, 0);
    add("s4_k2", 0, 0, kd(2), 1, 1, 2, 1, 16'h1234, 0);
    add("s4_prog_k7", 0, 1, kd(7), 1, 1, 0, 1, 16'h1234, 0);
    add("s4_k4", 0, 0, kd(4), 1, 1, 1, 1, 16'h1234, 0);
    add("s4_k5", 0, 0, kd(5), 1, 1, 2, 1, 16'h1234, 0);
    add("s4_k6", 0, 0, kd(6), 1, 1, 3, 1, 16'h1234, 0);
`ifdef PASSWORD_CONFIRM_EN
    add("s4_k8", 0, 0, kd(8), 1, 2, 0, 1, 16'h1234, 0);
    add("s4_c4", 0, 0, kd(4), 1, 2, 1, 1, 16'h1234, 0);
    add("s4_c5", 0, 0, kd(5), 1, 2, 2, 1, 16'h1234, 0);
    add("s4_c6", 0, 0, kd(6), 1, 2, 3, 1, 16'h1234, 0);
    add("s4_c8", 0, 0, kd(8), 1, 3, 0, 0, 16'h4568, 1);
`else
    add("s4_k8", 0, 0, kd(8), 1, 3, 0, 0, 16'h4568, 1);
`endif
    // Scenario 5: reset in the middle of an entry restores everything.
    add("s5_rst0", 1, 0, 0, 1, 0, 0, 1, 16'h1234, 0);
    add("s5_prog", 0, 1, 0, 1, 1, 0, 1, 16'h1234, 0);
`ifdef PASSWORD_CONFIRM_EN
    add("s5_k6", 0, 0, kd(6), 1, 1, 1, 1, 16'h1234, 0);
    add("s5_k7", 0, 0, kd(7), 1, 1, 2, 1, 16'h1234, 0);
    add("s5_k8", 0, 0, kd(8), 1, 1, 3, 1, 16'h1234, 0);
    add("s5_k9", 0, 0, kd(9), 1, 2, 0, 1, 16'h1234, 0);
    add("s5_c6", 0, 0, kd(6), 1, 2, 1, 1, 16'h1234, 0);
    add("s5_c7", 0, 0, kd(7), 1, 2, 2, 1, 16'h1234, 0);
    add("s5_c8", 0, 0, kd(8), 1, 2, 3, 1, 16'h1234, 0);
`else
    add("s5_k6", 0, 0, kd(6), 1, 1, 1, 1, 16'h1234, 0);
    add("s5_k7", 0, 0, kd(7), 1, 1, 2, 1, 16'h1234, 0);
    add("s5_k8", 0, 0, kd(8), 1, 1, 3, 1, 16'h1234, 0);
`endif
    add("s5_rst", 1, 0, 0, 1, 0, 0, 1, 16'h1234, 0);
    add("s5_idle", 0, 0, kd(3), 1, 0, 0, 1, 16'h1234, 0);
    run_table();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
